// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the CPU memory/IO responder.
//
// Contents:
//   IO_BASE / IO_UART / IO_CLK : byte addresses of the IO window and its ports
//   IO_SEL                     : value of address bits 17:16 that selects IO
//   acc_t                      : decoded bus access kind for one cycle
//   decode_acc()               : maps (rdy, wr, address) to an acc_t
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_UART = 18'h30000;
  localparam logic [17:0] IO_CLK  = 18'h30004;

  // Upper two decoded address bits select the IO window; everything else is RAM.
  localparam logic [1:0]  IO_SEL  = IO_BASE[17:16];

  // Counter snapshot byte addresses following the low-byte port.
  localparam logic [17:0] IO_CLK_B1 = 18'h30005;
  localparam logic [17:0] IO_CLK_B2 = 18'h30006;
  localparam logic [17:0] IO_CLK_B3 = 18'h30007;

  typedef enum logic [2:0] {
    ACC_IDLE   = 3'd0,
    ACC_RAM_RD = 3'd1,
    ACC_RAM_WR = 3'd2,
    ACC_IO_RD  = 3'd3,
    ACC_IO_WR  = 3'd4
  } acc_t;

  // A bus cycle only exists while rdy is high.
  function automatic acc_t decode_acc(input logic rdy, input logic wr,
                                      input logic [17:0] a);
    if (!rdy) return ACC_IDLE;
    if (a[17:16] == IO_SEL) return wr ? ACC_IO_WR : ACC_IO_RD;
    return wr ? ACC_RAM_WR : ACC_RAM_RD;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: small synchronous byte FIFO used as the UART TX buffer.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : write request and data; taken when not full, or when full
//                   but a pop happens in the same cycle
//   pop           : read request; ignored while empty
//   dout          : head byte, forced to 0 while empty
//   count         : number of stored bytes (FIFO_LOG+1 bits)
//   empty, full   : status flags derived from count
module byte_fifo #(
  parameter int FIFO_LOG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic [FIFO_LOG:0]   count,
  output logic                empty,
  output logic                full
);

  localparam int                DEPTH   = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] CNT_MAX = (FIFO_LOG + 1)'(DEPTH);
  localparam logic [FIFO_LOG:0] CNT_ONE = (FIFO_LOG + 1)'(1);
  localparam logic [FIFO_LOG-1:0] PTR_ONE = FIFO_LOG'(1);

  logic [7:0]          store [DEPTH];
  logic [FIFO_LOG-1:0] wr_ptr;
  logic [FIFO_LOG-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  // A pop frees the head slot in the same edge, so a full FIFO can still
  // accept a push when it is also being drained.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = empty ? 8'h00 : store[rd_ptr];

  // Storage is not reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  // Pointers are FIFO_LOG bits wide and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder on the CPU byte-wide memory bus.
//
// Serves a 128 KB RAM, the UART data port at 0x30000 and the cycle counter /
// program-stop port at 0x30004. Outgoing UART bytes are buffered in a TX FIFO.
//
// Ports:
//   clk_in, rst_in   : clock, synchronous active-high reset
//   rdy_in           : bus cycle qualifier; nothing happens on the bus when low
//   mem_a            : CPU byte address (bits 17:0 decoded)
//   mem_dout, mem_wr : CPU write data, 1 = write / 0 = read
//   mem_din          : registered read data, valid one cycle after the address
//   io_buffer_full   : registered "TX FIFO nearly full" flag back to the CPU
//   rx_valid/rx_data : UART receive byte; rx_pop consumes it (same cycle)
//   tx_valid/tx_data : TX FIFO head towards the UART; tx_ready accepts it
//   program_stop     : sticky, set by a write to 0x30004
//   tx_overflow      : sticky, set when a byte is dropped on a full FIFO
//
// TX handshake: tx_valid is high whenever the FIFO holds a byte and tx_data is
// the head byte; a byte transfers on every rising edge where tx_valid and
// tx_ready are both high. tx_valid/tx_data do not depend on tx_ready, and the
// transfer is independent of rdy_in.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int FIFO_LOG    = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int                RAM_DEPTH  = 1 << RAM_AW;
  localparam logic [FIFO_LOG:0] FULL_LEVEL =
    (FIFO_LOG + 1)'((1 << FIFO_LOG) - FULL_MARGIN);

  logic [7:0]        ram [RAM_DEPTH];
  logic [17:0]       a18;
  logic [RAM_AW-1:0] ram_idx;
  acc_t              acc;

  logic [31:0]       counter;
  logic [23:0]       snapshot;
  logic [7:0]        io_rd_data;

  logic              io_wr_ok;
  logic              push_req;
  logic [7:0]        push_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_LOG:0] fifo_count;
  logic              drop;

  // Address bits above 17 are not decoded.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^mem_a[31:18];

  assign a18     = mem_a[17:0];
  assign ram_idx = mem_a[RAM_AW-1:0];
  assign acc     = decode_acc(rdy_in, mem_wr, a18);

  // ---------------------------------------------------------------------------
  // IO read mux. Bytes 1..3 of the counter come from the snapshot taken when
  // the low byte was read, so a 4-byte read sees one consistent value.
  // ---------------------------------------------------------------------------
  always_comb begin
    io_rd_data = 8'h00;
    case (a18)
      IO_UART:   io_rd_data = rx_valid ? rx_data : 8'h00;
      IO_CLK:    io_rd_data = counter[7:0];
      IO_CLK_B1: io_rd_data = snapshot[7:0];
      IO_CLK_B2: io_rd_data = snapshot[15:8];
      IO_CLK_B3: io_rd_data = snapshot[23:16];
      default:   io_rd_data = 8'h00;
    endcase
  end

  // The UART byte is consumed in the same cycle the CPU reads it, so the
  // receiver can present the next byte for the following read.
  assign rx_pop = !rst_in && (acc == ACC_IO_RD) && (a18 == IO_UART) && rx_valid;

  // ---------------------------------------------------------------------------
  // IO writes. After program_stop every IO write is ignored; RAM is unaffected.
  // A write of 0x00 to the UART port is a no-op; the stop port emits 0x00.
  // ---------------------------------------------------------------------------
  assign io_wr_ok  = (acc == ACC_IO_WR) && !program_stop;
  assign push_req  = io_wr_ok &&
                     (((a18 == IO_UART) && (mem_dout != 8'h00)) || (a18 == IO_CLK));
  assign push_data = (a18 == IO_CLK) ? 8'h00 : mem_dout;

  // A full FIFO only loses the byte when nothing is popped in the same cycle.
  assign drop = push_req && fifo_full && !tx_ready;

  byte_fifo #(
    .FIFO_LOG(FIFO_LOG)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push_req),
    .pop   (tx_ready),
    .din   (push_data),
    .dout  (tx_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign tx_valid = !fifo_empty;

  // ---------------------------------------------------------------------------
  // RAM array: written in the address cycle, no wait state, never reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (acc == ACC_RAM_WR) ram[ram_idx] <= mem_dout;
  end

  // ---------------------------------------------------------------------------
  // Registered responder state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din        <= 8'h00;
      counter        <= 32'h0;
      snapshot       <= 24'h0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      // Counter only advances on live bus cycles and wraps naturally.
      if (rdy_in) counter <= counter + 32'd1;

      // Follows the FIFO count with one cycle of delay.
      io_buffer_full <= (fifo_count >= FULL_LEVEL);

      if (drop) tx_overflow <= 1'b1;
      if (io_wr_ok && (a18 == IO_CLK)) program_stop <= 1'b1;

      // Writes and idle cycles leave mem_din holding its last value.
      case (acc)
        ACC_RAM_RD: mem_din <= ram[ram_idx];
        ACC_IO_RD: begin
          mem_din <= io_rd_data;
          if (a18 == IO_CLK) snapshot <= counter[31:8];
        end
        default: mem_din <= mem_din;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed steps followed by a randomized phase,
// all compared against a transaction-level model (associative RAM, byte queue
// for the TX FIFO, integer cycle counter).
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_stop;
  logic        tx_overflow;

  int checks   = 0;
  int failures = 0;

  // Model state.
  logic [7:0]  ram_m [int];
  logic [7:0]  exp_q [$];
  logic [7:0]  dut_log [$];
  logic [31:0] m_cnt;
  logic [23:0] m_snap;
  logic [7:0]  m_din;
  logic        m_stop;
  logic        m_ovf;
  logic        m_full;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_pop         (rx_pop),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  // Clock.
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 32'h0;
    m_snap = 24'h0;
    m_din  = 8'h00;
    m_stop = 1'b0;
    m_ovf  = 1'b0;
    m_full = 1'b0;
  endtask

  // Reset for n edges with the given bus request presented, then check the
  // reset values of every output.
  task automatic do_reset(input int n, input logic r, input logic [31:0] a);
    rst_in = 1'b1; rdy_in = r; mem_a = a; mem_wr = 1'b0; mem_dout = 8'h00;
    rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (n) @(posedge clk_in);
    #1;
    rst_in = 1'b0; rdy_in = 1'b0;
    model_reset();
    #1;
    chk("rst_mem_din", mem_din, 8'h00);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_io_full", io_buffer_full, 1'b0);
    chk("rst_stop", program_stop, 1'b0);
    chk("rst_ovf", tx_overflow, 1'b0);
  endtask

  // One bus cycle: drive, check combinational outputs, advance the model,
  // clock, then check registered outputs.
  task automatic step(input logic r, input logic [31:0] a, input logic [7:0] d,
                      input logic w, input logic rv, input logic [7:0] rxd,
                      input logic tr);
    logic        io;
    logic [17:0] off;
    int          idx;
    int          size0;
    logic        popping;
    rdy_in = r; mem_a = a; mem_dout = d; mem_wr = w;
    rx_valid = rv; rx_data = rxd; tx_ready = tr;
    #1;
    io    = (a[17:16] == 2'b11);
    off   = a[17:0];
    idx   = int'(a[16:0]);
    size0 = exp_q.size();
    chk("rx_pop", rx_pop, r && !w && io && (off == 18'h30000) && rv);
    chk("tx_valid", tx_valid, size0 != 0);
    if (size0 != 0) chk("tx_data", tx_data, exp_q[0]);
    popping = tr && (size0 != 0);
    if (tx_valid && tr) dut_log.push_back(tx_data);

    if (r && !w) begin
      if (!io) m_din = ram_m[idx];
      else begin
        case (off)
          18'h30000: m_din = rv ? rxd : 8'h00;
          18'h30004: begin m_din = m_cnt[7:0]; m_snap = m_cnt[31:8]; end
          18'h30005: m_din = m_snap[7:0];
          18'h30006: m_din = m_snap[15:8];
          18'h30007: m_din = m_snap[23:16];
          default:   m_din = 8'h00;
        endcase
      end
    end
    if (r && w) begin
      if (!io) ram_m[idx] = d;
      else if (!m_stop) begin
        if ((off == 18'h30000 && d != 8'h00) || off == 18'h30004) begin
          if (size0 < 16 || popping) exp_q.push_back(off == 18'h30004 ? 8'h00 : d);
          else m_ovf = 1'b1;
          if (off == 18'h30004) m_stop = 1'b1;
        end
      end
    end
    if (popping) void'(exp_q.pop_front());
    m_full = (size0 >= 14);
    if (r) m_cnt = m_cnt + 32'd1;

    @(posedge clk_in);
    #1;
    chk("mem_din", mem_din, m_din);
    chk("io_buffer_full", io_buffer_full, m_full);
    chk("program_stop", program_stop, m_stop);
    chk("tx_overflow", tx_overflow, m_ovf);
  endtask

  // Harmless bus cycle: RAM write of 0 to a scratch byte (or no bus cycle).
  task automatic idle(input logic r, input logic tr);
    step(r, 32'h0001_FFF0, 8'h00, 1'b1, 1'b0, 8'h00, tr);
  endtask

  task automatic io_wr(input logic [31:0] a, input logic [7:0] d, input logic tr);
    step(1'b1, a, d, 1'b1, 1'b0, 8'h00, tr);
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic rv, input logic [7:0] rxd);
    step(1'b1, a, 8'h00, 1'b0, rv, rxd, 1'b0);
  endtask

  initial begin
    logic [16:0] pool [8];
    pool = '{17'h00000, 17'h00010, 17'h00FFF, 17'h01234, 17'h0ABCD, 17'h10000, 17'h1FFFE, 17'h1FFFF};

    rst_in = 1'b1; rdy_in = 1'b0; mem_a = '0; mem_dout = '0; mem_wr = 1'b0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    model_reset();

    // Reset values.
    do_reset(3, 1'b0, 32'h0);

    // RAM write then read: data one cycle after the read address.
    step(1'b1, 32'h0000_0010, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    bus_rd(32'h0000_0010, 1'b0, 8'h00);
    chk("ram_rd_a5", mem_din, 8'hA5);

    // UART writes 0x41, 0x00, 0x42 with tx_ready high.
    dut_log.delete();
    io_wr(32'h0003_0000, 8'h41, 1'b1);
    io_wr(32'h0003_0000, 8'h00, 1'b1);
    io_wr(32'h0003_0000, 8'h42, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b1);
    chk("uart_seq_len", dut_log.size(), 2);
    chk("uart_seq_0", dut_log[0], 8'h41);
    chk("uart_seq_1", dut_log[1], 8'h42);
    chk("uart_no_ovf", tx_overflow, 1'b0);

    // Fill with tx_ready low: full flag, then overflow on the 17th byte.
    for (int i = 1; i <= 14; i++) io_wr(32'h0003_0000, 8'(i), 1'b0);
    chk("full_lags_count", io_buffer_full, 1'b0);
    idle(1'b1, 1'b0);
    chk("full_after_14", io_buffer_full, 1'b1);
    io_wr(32'h0003_0000, 8'd15, 1'b0);
    io_wr(32'h0003_0000, 8'd16, 1'b0);
    chk("no_ovf_at_16", tx_overflow, 1'b0);
    io_wr(32'h0003_0000, 8'd17, 1'b0);
    chk("ovf_at_17", tx_overflow, 1'b1);
    // Push on a full FIFO while popping is accepted.
    io_wr(32'h0003_0000, 8'd18, 1'b1);
    for (int i = 0; i < 20; i++) idle(1'b1, 1'b1);
    chk("drained", tx_valid, 1'b0);

    // Cycle counter: 300 cycles from reset with 50 of them stalled.
    do_reset(2, 1'b0, 32'h0);
    for (int i = 0; i < 100; i++) idle(1'b1, 1'b0);
    for (int i = 0; i < 50; i++) idle(1'b0, 1'b0);
    for (int i = 0; i < 150; i++) idle(1'b1, 1'b0);
    bus_rd(32'h0003_0004, 1'b0, 8'h00);
    chk("cnt_lo_250", mem_din, 8'hFA);
    bus_rd(32'h0003_0005, 1'b0, 8'h00);
    chk("cnt_b1", mem_din, 8'h00);
    bus_rd(32'h0003_0006, 1'b0, 8'h00);
    bus_rd(32'h0003_0007, 1'b0, 8'h00);
    idle(1'b1, 1'b0);
    bus_rd(32'h0003_0004, 1'b0, 8'h00);
    chk("cnt_lo_255", mem_din, 8'hFF);
    bus_rd(32'h0003_0005, 1'b0, 8'h00);
    chk("snap_coherent", mem_din, 8'h00);

    // UART receive.
    bus_rd(32'h0003_0000, 1'b1, 8'h7E);
    chk("rx_byte", mem_din, 8'h7E);
    bus_rd(32'h0003_0000, 1'b0, 8'h99);
    chk("rx_empty", mem_din, 8'h00);

    // Randomized phase.
    do_reset(1, 1'b0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic        tr;
      int          op;
      logic [16:0] ra;
      logic [13:0] hi;
      r  = (($urandom_range(0, 9)) != 0);
      tr = (($urandom_range(0, 3)) != 0);
      op = $urandom_range(0, 4);
      ra = pool[$urandom_range(0, 7)];
      hi = 14'($urandom);
      if (op == 1 && !ram_m.exists(int'(ra))) op = 0;
      case (op)
        0: step(r, {hi, 1'b0, ra}, 8'($urandom), 1'b1, 1'b0, 8'h00, tr);
        1: step(r, {hi, 1'b0, ra}, 8'h00, 1'b0, 1'b0, 8'h00, tr);
        2, 3: step(r, {hi, 18'h30000}, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                   1'b1, 1'b0, 8'h00, tr);
        default: step(r, {hi, 18'h30000 + 18'($urandom_range(0, 8))}, 8'h00, 1'b0,
                      1'($urandom), 8'($urandom), tr);
      endcase
    end
    for (int i = 0; i < 20; i++) idle(1'b1, 1'b1);

    // Reset in the middle of a read with bytes queued.
    io_wr(32'h0003_0000, 8'h11, 1'b0);
    io_wr(32'h0003_0000, 8'h22, 1'b0);
    do_reset(1, 1'b1, 32'h0000_0010);

    // Program stop.
    io_wr(32'h0003_0004, 8'h00, 1'b0);
    chk("stop_set", program_stop, 1'b1);
    chk("stop_tx_valid", tx_valid, 1'b1);
    chk("stop_tx_zero", tx_data, 8'h00);
    io_wr(32'h0003_0000, 8'h55, 1'b1);
    chk("after_stop_empty", tx_valid, 1'b0);
    step(1'b1, 32'h0000_0020, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0);
    bus_rd(32'h0000_0020, 1'b0, 8'h00);
    chk("ram_after_stop", mem_din, 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
